// File: rtl/timer_keypad_entry.sv
// Keypad entry stage of the microwave timer: shifts BCD digits into an MM:SS
// register, validates on START and pulses load to the down-counter digit chain.
//
// state  | meaning
// IDLE   | no digits entered, all digits zero
// ENTRY  | one or more digits entered, waiting for more digits, CLEAR or START
// LOADED | digits handed to the timer, entry locked until CLEAR or cook finish
module timer_keypad_entry #(
   parameter logic [3:0] QUICK_SEC_TENS = 4'd3,
   parameter int         MAX_DIGITS     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       cooking,
   output logic [3:0] sec_units,
   output logic [3:0] sec_tens,
   output logic [3:0] min_units,
   output logic [3:0] min_tens,
   output logic       load,
   output logic       entry_err,
   output logic [2:0] digit_count,
   output logic       locked
);

   typedef enum logic [1:0] {IDLE, ENTRY, LOADED} state_t;

   localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

   state_t     state, state_nxt;
   logic [3:0] su_nxt, st_nxt, mu_nxt, mt_nxt;
   logic [2:0] cnt_nxt;
   logic       load_nxt, err_nxt;
   logic       cooking_prev;

   logic is_digit, is_clear, is_start, cook_fall, all_zero;

   assign is_digit  = key_valid && (key_code <= 4'd9);
   assign is_clear  = key_valid && (key_code == 4'd10);
   assign is_start  = key_valid && (key_code == 4'd11);
   assign cook_fall = cooking_prev && !cooking;
   assign all_zero  = ({min_tens, min_units, sec_tens, sec_units} == 16'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         sec_units    <= '0;
         sec_tens     <= '0;
         min_units    <= '0;
         min_tens     <= '0;
         digit_count  <= '0;
         load         <= 1'b0;
         entry_err    <= 1'b0;
         cooking_prev <= 1'b0;
      end else begin
         state        <= state_nxt;
         sec_units    <= su_nxt;
         sec_tens     <= st_nxt;
         min_units    <= mu_nxt;
         min_tens     <= mt_nxt;
         digit_count  <= cnt_nxt;
         load         <= load_nxt;
         entry_err    <= err_nxt;
         cooking_prev <= cooking;
      end
   end

   always_comb begin
      state_nxt = state;
      su_nxt    = sec_units;
      st_nxt    = sec_tens;
      mu_nxt    = min_units;
      mt_nxt    = min_tens;
      cnt_nxt   = digit_count;
      load_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (is_digit) begin
               su_nxt    = key_code;
               cnt_nxt   = 3'd1;
               state_nxt = ENTRY;
            end else if (is_start) begin
               su_nxt    = '0;
               st_nxt    = QUICK_SEC_TENS;
               mu_nxt    = '0;
               mt_nxt    = '0;
               load_nxt  = 1'b1;
               state_nxt = LOADED;
            end
         end
         ENTRY: begin
            if (is_digit) begin
               if (digit_count < MAX_CNT) begin
                  mt_nxt  = min_units;
                  mu_nxt  = sec_tens;
                  st_nxt  = sec_units;
                  su_nxt  = key_code;
                  cnt_nxt = digit_count + 3'd1;
               end
            end else if (is_clear) begin
               su_nxt    = '0;
               st_nxt    = '0;
               mu_nxt    = '0;
               mt_nxt    = '0;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else if (is_start) begin
               // all-zero entry ("0","0") behaves like a bare START
               if (all_zero) begin
                  st_nxt    = QUICK_SEC_TENS;
                  load_nxt  = 1'b1;
                  state_nxt = LOADED;
               end else if (sec_tens <= 4'd5) begin
                  load_nxt  = 1'b1;
                  state_nxt = LOADED;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         LOADED: begin
            if (is_clear || cook_fall) begin
               su_nxt    = '0;
               st_nxt    = '0;
               mu_nxt    = '0;
               mt_nxt    = '0;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      locked = (state == LOADED);
   end

endmodule

// File: tb/tb_timer_keypad_entry.sv
// Bench for timer_keypad_entry: directed scenarios then random key/cooking
// traffic, compared each cycle against an arithmetic MM:SS reference model.
module tb_timer_keypad_entry;

   localparam int QUICK = 3;

   logic       clk = 1'b0;
   logic       reset, key_valid, cooking;
   logic [3:0] key_code;
   logic [3:0] sec_units, sec_tens, min_units, min_tens;
   logic       load, entry_err, locked;
   logic [2:0] digit_count;

   int checks = 0;
   int failures = 0;

   // reference model: entered value as a decimal number MMSS
   int val = 0;
   int cnt = 0;
   bit loaded = 0;
   bit prev_cook = 0;
   bit exp_load = 0;
   bit exp_err = 0;

   timer_keypad_entry #(.QUICK_SEC_TENS(4'(QUICK)), .MAX_DIGITS(4)) dut (
      .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
      .cooking(cooking), .sec_units(sec_units), .sec_tens(sec_tens),
      .min_units(min_units), .min_tens(min_tens), .load(load),
      .entry_err(entry_err), .digit_count(digit_count), .locked(locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model(input bit kv, input int code, input bit ck, input bit rst);
      exp_load = 0;
      exp_err  = 0;
      if (rst) begin
         val = 0; cnt = 0; loaded = 0; prev_cook = 0;
         return;
      end
      if (loaded) begin
         if ((kv && code == 10) || (prev_cook && !ck)) begin
            val = 0; cnt = 0; loaded = 0;
         end
      end else if (kv) begin
         if (code <= 9) begin
            if (cnt < 4) begin
               val = (val * 10 + code) % 10000;
               cnt++;
            end
         end else if (code == 10) begin
            val = 0; cnt = 0;
         end else if (code == 11) begin
            if (val == 0) begin
               val = QUICK * 10; exp_load = 1; loaded = 1;
            end else if ((val / 10) % 10 <= 5) begin
               exp_load = 1; loaded = 1;
            end else begin
               exp_err = 1;
            end
         end
      end
      prev_cook = ck;
   endtask

   task automatic step(input bit kv, input int code, input bit ck, input bit rst);
      key_valid = kv;
      key_code  = 4'(code);
      cooking   = ck;
      reset     = rst;
      @(posedge clk);
      #1;
      model(kv, code, ck, rst);
      check("sec_units", int'(sec_units), val % 10);
      check("sec_tens", int'(sec_tens), (val / 10) % 10);
      check("min_units", int'(min_units), (val / 100) % 10);
      check("min_tens", int'(min_tens), val / 1000);
      check("digit_count", int'(digit_count), cnt);
      check("load", int'(load), int'(exp_load));
      check("entry_err", int'(entry_err), int'(exp_err));
      check("locked", int'(locked), int'(loaded));
   endtask

   initial begin
      int d, code;
      bit ck;
      key_valid = 0; key_code = 0; cooking = 0; reset = 1;
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      // 1,3,0 START -> 01:30 loaded, then cook cycle ends
      step(1, 1, 0, 0); step(1, 3, 0, 0); step(1, 0, 0, 0); step(1, 11, 0, 0);
      step(0, 0, 0, 0); step(0, 0, 1, 0); step(1, 5, 1, 0); step(0, 0, 0, 0);
      // five digits, fifth ignored, then CLEAR
      step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 4, 0, 0);
      step(1, 5, 0, 0); step(1, 10, 0, 0);
      // 9,0 START -> error, stays in entry, then CLEAR
      step(1, 9, 0, 0); step(1, 0, 0, 0); step(1, 11, 0, 0); step(0, 0, 0, 0);
      step(1, 11, 0, 0); step(1, 10, 0, 0);
      // quick start from idle, digit while locked, cooking pulse
      step(1, 11, 0, 0); step(1, 7, 0, 0); step(1, 11, 0, 0);
      step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 0, 0);
      // leading zeros only -> quick start
      step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 11, 0, 0); step(1, 10, 0, 0);
      // reset beats START
      step(1, 4, 0, 0); step(1, 5, 0, 0); step(1, 11, 0, 1); step(0, 0, 0, 0);
      // CLEAR and cooking fall in the same cycle
      step(1, 2, 0, 0); step(1, 11, 0, 0); step(0, 0, 1, 0); step(1, 10, 0, 0);
      step(0, 0, 0, 0);
      // ignored codes in idle and entry
      step(1, 13, 0, 0); step(1, 8, 0, 0); step(1, 15, 0, 0); step(1, 10, 0, 0);
      // random traffic
      ck = 0;
      for (int i = 0; i < 3000; i++) begin
         d = $urandom_range(0, 99);
         if (d < 55) code = $urandom_range(0, 9);
         else if (d < 70) code = 11;
         else if (d < 78) code = 10;
         else code = $urandom_range(12, 15);
         if ($urandom_range(0, 7) == 0) ck = !ck;
         step($urandom_range(0, 2) != 0, code, ck, $urandom_range(0, 199) == 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/timer_keypad_entry.md
Name: timer_keypad_entry

Overview:
- Upstream stage of the microwave timer digit chain.
- Accepts decoded keypad strokes and shifts BCD digits into an MM:SS entry register.
- Validates the entry and issues a one-cycle load pulse, with parallel digit values, to the mod-6/mod-10 down-counter digits.
- Locks out entry while cooking is in progress.

Parameters:
- QUICK_SEC_TENS, 3, seconds-tens digit loaded on START with no digits entered (quick start 0:30).
- MAX_DIGITS, 4, maximum accepted digits; further digits are ignored.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- key_valid  input  1  one-cycle strobe; key_code is valid when high.
- key_code  input  4  0-9 digit, 10 = CLEAR, 11 = START, 12-15 ignored.
- cooking  input  1  high while the timer is counting down (from the controller).
- sec_units  output  4  BCD seconds units, to the mod-10 digit load input.
- sec_tens  output  4  BCD seconds tens, to the mod-6 digit load input.
- min_units  output  4  BCD minutes units.
- min_tens  output  4  BCD minutes tens.
- load  output  1  one-cycle pulse; timer digits sample the digit outputs on it.
- entry_err  output  1  one-cycle pulse on a rejected START.
- digit_count  output  3  number of digits entered, 0..MAX_DIGITS.
- locked  output  1  high in LOADED state.

Behaviour:
- Clock and reset: all state updates on the rising edge of clk. reset is synchronous and active-high.
- Reset values: all digits 0, digit_count 0, load 0, entry_err 0, locked 0, state IDLE.
- Reset mid-operation has priority over any key in the same cycle.
- States: IDLE, ENTRY, LOADED.

IDLE
- Digit key d: sec_units <= d, digit_count <= 1, go to ENTRY. Digit 0 is also accepted, which allows leading zeros.
- START: load quick-start value 00:QUICK_SEC_TENS,0, i.e. sec_tens = QUICK_SEC_TENS and all other digits 0. Pulse load, go to LOADED.
- CLEAR or code 12-15: no effect.

ENTRY
- Digit d with digit_count < MAX_DIGITS: shift left one digit and increment digit_count.
  - min_tens <= min_units, min_units <= sec_tens, sec_tens <= sec_units, sec_units <= d.
- Digit with digit_count == MAX_DIGITS: ignored, nothing changes.
- CLEAR: all digits 0, digit_count 0, go to IDLE.
- START with sec_tens <= 5: pulse load for exactly one cycle, go to LOADED. Digits are held unchanged.
- START with sec_tens > 5: pulse entry_err for one cycle and stay in ENTRY. Digits are unchanged and no load occurs.
- START with all four digits zero (e.g. "0","0"): treated as quick start, same as the IDLE START case.

LOADED
- locked = 1. Digit keys and START are ignored.
- CLEAR: zero all digits and digit_count, go to IDLE, locked 0. This acts as an abort; the controller stops the timer independently.
- A falling edge of cooking (registered previous value 1, current 0) zeroes all digits, clears digit_count and returns to IDLE.
- cooking held low from entry onward: stay in LOADED until cooking has risen and then fallen, or until CLEAR.
- CLEAR and a cooking falling edge in the same cycle: same result, IDLE with zeros.

Timing and output rules:
- load latency: asserted in the cycle after the clock edge that sampled key_valid with START. Digit outputs are stable on that edge and on every later edge until the next change.
- entry_err and load are mutually exclusive and never asserted for two consecutive cycles.
- Digit outputs are registered and never carry non-BCD values (digit keys are 0-9 only).

Test Plan:
- Keys 1,3,0 then START -> digits 0,1,3,0 (01:30); digit_count 3; load high exactly one cycle after START; locked 1.
- Keys 1,2,3,4,5 -> fifth key ignored; outputs 12:34; digit_count 4.
- Keys 9,0 then START -> entry_err one-cycle pulse; no load; state stays ENTRY; digits 00:90. Then CLEAR -> all zero, IDLE.
- START from reset -> outputs 00:30, load pulse. Digit key 7 while locked -> no change. cooking 0->1->0 -> zeros, locked 0, IDLE.
- Keys 4,5, then reset asserted in the same cycle as key_valid with START -> all outputs 0, no load, IDLE.
- In LOADED, CLEAR and a cooking falling edge in the same cycle -> IDLE, digits 0, no load or entry_err pulse.
